cache_port_arbiter: RTL and testbench
=====================================

// Module: cache_port_arbiter
// PURPOSE
//  Shares one directly-mapped cache read port among NREQ basic-block requesters.
//  Round-robin arbitration; grant locked until the downstream accepts.
//  Address latched at grant, so the downstream sees it stable until it accepts.
//  Returned data goes to the winning requester on the following cycle. Read-only.
// PARAMETERS
//  NREQ        4   number of requesters, >=2
//  ADDR_WIDTH  16  address width, same as the cache
//  DWIDTH      20  data width, same as the cache
// PORTS
//  clk             in   1                clock
//  rst             in   1                reset, synchronous, active-high
//  req_valid       in   NREQ             per-requester address valid
//  req_addr        in   NREQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//  req_ready       out  NREQ             one-hot; request i accepted this cycle
//  req_data        out  DWIDTH           returned data, shared by all requesters
//  req_data_valid  out  NREQ             one-hot; req_data belongs to requester i this cycle
//  mem_addr_valid  out  1                to cache addr_in_valid
//  mem_addr        out  ADDR_WIDTH       to cache addr_in
//  mem_addr_ready  in   1                from cache addr_in_ready
//  mem_data        in   DWIDTH           from cache data_out; valid the cycle after mem_addr_ready
// BEHAVIOUR
//  Reset values: state S_IDLE, rr pointer 0, all outputs 0, data-return pipeline cleared.
//  Reset mid-transaction drops the transaction; no req_data_valid is issued afterwards.
//  FSM (state in cache_arb_pkg):
//   S_IDLE: if any req_valid, pick winner g by round-robin from ptr.
//     Register g and addr[g]; go to S_BUSY. Outputs stay 0.
//   S_BUSY: mem_addr_valid=1, mem_addr=latched addr.
//     If mem_addr_ready: req_ready[g]=1, ptr<=(g+1)%NREQ, and go to S_IDLE.
//     Else stay in S_BUSY; grant and address held.
//  Back-to-back: in the completing S_BUSY cycle, arbitrate the other requesters (g masked).
//   If any is valid, load the new grant and address and stay in S_BUSY; no bubble.
//   If none is valid, go to S_IDLE.
//  Round-robin: first valid index at or after ptr, wrapping modulo NREQ.
//   ptr updates only on completion.
//  Data return: 1-cycle registered pipeline.
//   If req_ready[g] at cycle T: req_data_valid[g]=1 at T+1; req_data=mem_data, passed through combinationally.
//   req_data is unspecified when no data_valid bit is set.
//  Latency: req_valid at cycle 0 with arbiter idle and a cache hit.
//   mem_addr_valid at cycle 1; req_ready at cycle 1; data_valid at cycle 2.
//   A miss extends the wait by the cache fetch time.
//  Requester protocol: hold req_valid/req_addr until req_ready.
//   If a granted requester deasserts valid, the latched transaction still completes.
//   Its req_ready/req_data_valid are still pulsed; the requester ignores them.
//  Address changes on a granted requester are ignored until re-arbitration.
//  Simultaneous requests: exactly one grant; no requester starves.
//   Worst-case wait is NREQ-1 transactions.
//  Invariants: req_ready and req_data_valid each one-hot or zero.
//   mem_addr_valid never drops before mem_addr_ready.
// STRUCTURE
//  cache_arb_pkg: state typedef {S_IDLE,S_BUSY}; IDX_W=$clog2(NREQ) as a function/localparam helper.
//  Sub-module rr_priority_picker: combinational.
//   Inputs: req vector, ptr, mask vector.
//   Outputs: any_valid, winner index.
//  Top level: FSM, address/grant registers, data-return pipeline.
// TESTING
//  1. Single hit: req0 valid, addr=0x0012, cache hits.
//     -> mem_addr=0x0012 @c1, req_ready=0001 @c1, req_data_valid=0001 @c2, req_data=mem_data.
//  2. All four valid, all hits. -> grants in order 0,1,2,3,0, back-to-back with no idle cycles.
//  3. Miss stall: req2 granted, mem_addr_ready low 5 cycles.
//     -> mem_addr_valid held 6 cycles, mem_addr stable; req_ready[2] only in the accept cycle.
//  4. Fairness: req1 continuously valid, req3 asserted once. -> req3 served within 1 transaction after req1's current one.
//  5. Requester drops valid mid-grant.
//     -> transaction completes with the latched address; the next grant goes to the following valid requester.
//  6. rst asserted while in S_BUSY after mem_addr_ready.
//     -> next cycle all outputs 0, no req_data_valid, ptr=0.

Source files
------------

// File: rtl/cache_arb_pkg.sv
// Shared types and helpers for the cache read-port arbiter.
package cache_arb_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } arb_state_e;

  // Index width for a requester count, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first unmasked valid index at or after ptr.
module rr_priority_picker
  import cache_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = idx_w(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  input  logic [NREQ-1:0]  mask,
  output logic             any_valid,
  output logic [IDX_W-1:0] winner
);

  logic [NREQ-1:0] eff;

  assign eff = req & ~mask;

  // Walk offsets from the farthest back to ptr so the closest hit wins.
  always_comb begin
    any_valid = 1'b0;
    winner    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(ptr) + k) % NREQ;
      if (eff[idx]) begin
        any_valid = 1'b1;
        winner    = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// Round-robin sharing of one cache read port; grant and address held until
// the cache accepts, data returned to the winner one cycle after acceptance.
module cache_port_arbiter
  import cache_arb_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DWIDTH     = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NREQ-1:0]            req_ready,
  output logic [DWIDTH-1:0]          req_data,
  output logic [NREQ-1:0]            req_data_valid,
  output logic                       mem_addr_valid,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  input  logic                       mem_addr_ready,
  input  logic [DWIDTH-1:0]          mem_data
);

  localparam int IDX_W = idx_w(NREQ);

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       gnt_q, gnt_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [NREQ-1:0]        dv_q;

  logic [IDX_W-1:0]       gnt_next_ptr;
  logic [IDX_W-1:0]       pick_ptr;
  logic [NREQ-1:0]        pick_mask;
  logic                   pick_any;
  logic [IDX_W-1:0]       pick_win;

  assign gnt_next_ptr = (gnt_q == IDX_W'(NREQ - 1)) ? '0 : gnt_q + 1'b1;

  // While busy, arbitration looks ahead for the next grant with the current
  // winner excluded, starting from where the pointer will land on completion.
  always_comb begin
    pick_mask = '0;
    pick_ptr  = ptr_q;
    if (state_q == S_BUSY) begin
      pick_mask[gnt_q] = 1'b1;
      pick_ptr         = gnt_next_ptr;
    end
  end

  rr_priority_picker #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req       (req_valid),
    .ptr       (pick_ptr),
    .mask      (pick_mask),
    .any_valid (pick_any),
    .winner    (pick_win)
  );

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    gnt_d          = gnt_q;
    addr_d         = addr_q;
    req_ready      = '0;
    mem_addr_valid = 1'b0;
    mem_addr       = '0;
    case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_win;
          addr_d  = req_addr[int'(pick_win)*ADDR_WIDTH +: ADDR_WIDTH];
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        mem_addr_valid = 1'b1;
        mem_addr       = addr_q;
        if (mem_addr_ready) begin
          req_ready[gnt_q] = 1'b1;
          ptr_d            = gnt_next_ptr;
          if (pick_any) begin
            gnt_d  = pick_win;
            addr_d = req_addr[int'(pick_win)*ADDR_WIDTH +: ADDR_WIDTH];
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      dv_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      dv_q    <= req_ready;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
  end

  // Cache data arrives the cycle after acceptance; steer it by the delayed grant.
  assign req_data_valid = dv_q;
  assign req_data       = (|dv_q) ? mem_data : '0;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter with hand-computed expectations.
module tb_cache_port_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 16;
  localparam int DW   = 20;

  logic             clk = 1'b0;
  logic             rst;
  logic [NREQ-1:0]  req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]  req_ready;
  logic [DW-1:0]    req_data;
  logic [NREQ-1:0]  req_data_valid;
  logic             mem_addr_valid;
  logic [AW-1:0]    mem_addr;
  logic             mem_addr_ready;
  logic [DW-1:0]    mem_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_port_arbiter #(
    .NREQ       (NREQ),
    .ADDR_WIDTH (AW),
    .DWIDTH     (DW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_ready      (req_ready),
    .req_data       (req_data),
    .req_data_valid (req_data_valid),
    .mem_addr_valid (mem_addr_valid),
    .mem_addr       (mem_addr),
    .mem_addr_ready (mem_addr_ready),
    .mem_data       (mem_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    req_valid      = '0;
    req_addr       = '0;
    mem_addr_ready = 1'b0;
    mem_data       = '0;
    tick();
    rst = 1'b0;
  endtask

  // Checks the combinational outputs of the current cycle.
  task automatic chk_out(input string tag, input logic mav, input logic [AW-1:0] ma,
                         input logic [NREQ-1:0] rr, input logic [NREQ-1:0] dv);
    #1;
    chk({tag, "_mav"}, 32'(mem_addr_valid), 32'(mav));
    if (mav) chk({tag, "_maddr"}, 32'(mem_addr), 32'(ma));
    chk({tag, "_rdy"}, 32'(req_ready), 32'(rr));
    chk({tag, "_dv"}, 32'(req_data_valid), 32'(dv));
  endtask

  initial begin
    // Reset state
    rst            = 1'b1;
    req_valid      = '0;
    req_addr       = '0;
    mem_addr_ready = 1'b1;
    mem_data       = 20'h5A5A5;
    tick();
    tick();
    #1;
    chk("rst_mav", 32'(mem_addr_valid), 32'd0);
    chk("rst_maddr", 32'(mem_addr), 32'd0);
    chk("rst_rdy", 32'(req_ready), 32'd0);
    chk("rst_dv", 32'(req_data_valid), 32'd0);
    chk("rst_data", 32'(req_data), 32'd0);

    // 1. Single hit
    do_reset();
    req_valid = 4'b0001; set_addr(0, 16'h0012); mem_addr_ready = 1'b1;
    chk_out("t1_c0", 1'b0, '0, 4'b0000, 4'b0000);
    tick();
    chk_out("t1_c1", 1'b1, 16'h0012, 4'b0001, 4'b0000);
    tick();
    req_valid = '0; mem_data = 20'hABCDE;
    chk_out("t1_c2", 1'b0, '0, 4'b0000, 4'b0001);
    chk("t1_data", 32'(req_data), 32'h000ABCDE);

    // 2. All four valid, back-to-back grants 0,1,2,3,0
    do_reset();
    for (int i = 0; i < NREQ; i++) set_addr(i, 16'h1000 + 16'(i));
    req_valid = 4'b1111; mem_addr_ready = 1'b1;
    chk_out("t2_c0", 1'b0, '0, 4'b0000, 4'b0000);
    tick();
    chk_out("t2_c1", 1'b1, 16'h1000, 4'b0001, 4'b0000);
    tick();
    mem_data = 20'h00111;
    chk_out("t2_c2", 1'b1, 16'h1001, 4'b0010, 4'b0001);
    chk("t2_d0", 32'(req_data), 32'h00000111);
    tick();
    chk_out("t2_c3", 1'b1, 16'h1002, 4'b0100, 4'b0010);
    tick();
    chk_out("t2_c4", 1'b1, 16'h1003, 4'b1000, 4'b0100);
    tick();
    chk_out("t2_c5", 1'b1, 16'h1000, 4'b0001, 4'b1000);

    // 3. Miss stall on requester 2
    do_reset();
    req_valid = 4'b0100; set_addr(2, 16'h2222); mem_addr_ready = 1'b0;
    chk_out("t3_c0", 1'b0, '0, 4'b0000, 4'b0000);
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk_out($sformatf("t3_stall%0d", c), 1'b1, 16'h2222, 4'b0000, 4'b0000);
    end
    tick();
    mem_addr_ready = 1'b1;
    chk_out("t3_acc", 1'b1, 16'h2222, 4'b0100, 4'b0000);
    tick();
    req_valid = '0; mem_data = 20'h22222;
    chk_out("t3_ret", 1'b0, '0, 4'b0000, 4'b0100);
    chk("t3_data", 32'(req_data), 32'h00022222);

    // 4. Fairness: req1 continuous, req3 once
    do_reset();
    req_valid = 4'b0010; set_addr(1, 16'h1111); mem_addr_ready = 1'b1;
    chk_out("t4_c0", 1'b0, '0, 4'b0000, 4'b0000);
    tick();
    req_valid = 4'b1010; set_addr(3, 16'h3333);
    chk_out("t4_c1", 1'b1, 16'h1111, 4'b0010, 4'b0000);
    tick();
    chk_out("t4_c2", 1'b1, 16'h3333, 4'b1000, 4'b0010);
    tick();
    req_valid = 4'b0010;
    chk_out("t4_c3", 1'b1, 16'h1111, 4'b0010, 4'b1000);

    // 5. Granted requester drops valid and changes address mid-grant
    do_reset();
    req_valid = 4'b0101; set_addr(0, 16'h0A0A); set_addr(2, 16'h0C0C);
    mem_addr_ready = 1'b0;
    chk_out("t5_c0", 1'b0, '0, 4'b0000, 4'b0000);
    tick();
    req_valid = 4'b0100; set_addr(0, 16'hFFFF);
    chk_out("t5_c1", 1'b1, 16'h0A0A, 4'b0000, 4'b0000);
    tick();
    mem_addr_ready = 1'b1;
    chk_out("t5_c2", 1'b1, 16'h0A0A, 4'b0001, 4'b0000);
    tick();
    chk_out("t5_c3", 1'b1, 16'h0C0C, 4'b0100, 4'b0001);
    tick();
    req_valid = '0;
    chk_out("t5_c4", 1'b0, '0, 4'b0000, 4'b0100);

    // 6. Reset in the accepting busy cycle
    do_reset();
    req_valid = 4'b0010; set_addr(1, 16'h0055); mem_addr_ready = 1'b1;
    tick();
    chk_out("t6_c1", 1'b1, 16'h0055, 4'b0010, 4'b0000);
    rst = 1'b1;
    tick();
    rst = 1'b0; req_valid = '0; mem_data = 20'h77777;
    chk_out("t6_c2", 1'b0, '0, 4'b0000, 4'b0000);
    chk("t6_maddr", 32'(mem_addr), 32'd0);
    chk("t6_data", 32'(req_data), 32'd0);
    tick();
    req_valid = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_addr(i, 16'h6000 + 16'(i));
    chk_out("t6_c3", 1'b0, '0, 4'b0000, 4'b0000);
    tick();
    chk_out("t6_c4", 1'b1, 16'h6000, 4'b0001, 4'b0000);
    tick();
    req_valid = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
